cla_slice_sequencer: RTL and testbench

Multi-cycle controller that performs a W-bit ALU operation by time-multiplexing one external N-bit carry-lookahead adder slice. Each cycle it drives one slice's operands and carry-in, then captures the slice's sum and carry-out. Logic operations are also walked slice-by-slice so latency does not depend on the opcode. It sits between the execute-stage issue logic and the shared CLA slice.

---
 rtl/cla_slice_sequencer_if.sv | 28 ++
 rtl/cla_slice_sequencer.sv | 152 +++++++++++++++
 tb/tb_cla_slice_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cla_slice_sequencer_if.sv
// rtl/cla_slice_sequencer_if.sv - bus between the sequencer and the shared CLA slice
interface cla_slice_sequencer_if #(
    parameter int N = 4
);
    logic [N-1:0] slice_a;
    logic [N-1:0] slice_b;
    logic         slice_cin;
    logic [N-1:0] slice_sum;
    logic         slice_cout;

    // Sequencer side: drives operands and carry-in, receives the combinational sum
    modport master (
        output slice_a,
        output slice_b,
        output slice_cin,
        input  slice_sum,
        input  slice_cout
    );

    // Adder side
    modport slave (
        input  slice_a,
        input  slice_b,
        input  slice_cin,
        output slice_sum,
        output slice_cout
    );
endinterface

// File: rtl/cla_slice_sequencer.sv
// rtl/cla_slice_sequencer.sv - W-bit ALU op walked slice-by-slice through one shared N-bit CLA
module cla_slice_sequencer #(
    parameter int N      = 4,
    parameter int SLICES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [N*SLICES-1:0]   a_i,
    input  logic [N*SLICES-1:0]   b_i,
    input  logic                  cin_i,
    cla_slice_sequencer_if.master cla,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [N*SLICES-1:0]   result_o,
    output logic                  cout_o,
    output logic                  ovf_o
);
    localparam int W  = N * SLICES;
    localparam int KW = (SLICES > 1) ? $clog2(SLICES) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;          // already inverted for SUB
    logic [1:0]     op_q, op_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   result_q, result_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;

    logic [N-1:0]   slice_a_w;
    logic [N-1:0]   slice_b_w;
    logic           slice_cin_w;
    logic [N-1:0]   logic_slice;
    logic           arith;
    logic           fin_cout;
    logic           fin_ovf;

    // Only ADD/SUB consume the adder output and carry chain; op bit 1 marks logic ops
    assign arith = ~op_q[1];

    // Final flags are formed in the DONE cycle from the completed result and last carry
    assign fin_cout = arith & carry_q;
    assign fin_ovf  = arith & (a_q[W-1] == b_q[W-1]) & (result_q[W-1] != a_q[W-1]);

    // Next-state, slice drive and datapath updates; everything holds unless a state says otherwise
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        carry_d     = carry_q;
        result_d    = result_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        slice_a_w   = '0;
        slice_b_w   = '0;
        slice_cin_w = 1'b0;
        logic_slice = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_d      = a_i;
                    op_d     = op_i;
                    b_d      = (op_i == OP_SUB) ? ~b_i : b_i;
                    carry_d  = (op_i == OP_SUB) ? 1'b1 : ((op_i == OP_ADD) ? cin_i : 1'b0);
                    k_d      = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                slice_a_w   = a_q[k_q*N +: N];
                slice_b_w   = b_q[k_q*N +: N];
                slice_cin_w = carry_q;
                logic_slice = (op_q == OP_AND) ? (slice_a_w & slice_b_w) : (slice_a_w | slice_b_w);
                if (arith) begin
                    result_d[k_q*N +: N] = cla.slice_sum;
                    carry_d              = cla.slice_cout;
                end else begin
                    result_d[k_q*N +: N] = logic_slice;
                end
                // MSB slice carry-out stays in carry_q for cout; it never loops back to slice 0
                if (k_q == KW'(SLICES - 1)) begin
                    k_d     = '0;
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DONE: begin
                cout_d  = fin_cout;
                ovf_d   = fin_ovf;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 2'b00;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign cla.slice_a   = slice_a_w;
    assign cla.slice_b   = slice_b_w;
    assign cla.slice_cin = slice_cin_w;

    assign busy_o   = (state_q == S_RUN) || (state_q == S_DONE);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;
    assign cout_o   = (state_q == S_DONE) ? fin_cout : cout_q;
    assign ovf_o    = (state_q == S_DONE) ? fin_ovf : ovf_q;
endmodule

// File: tb/tb_cla_slice_sequencer.sv
// tb/tb_cla_slice_sequencer.sv - directed vector bench for cla_slice_sequencer
module tb_cla_slice_sequencer;
    localparam int N      = 4;
    localparam int SLICES = 4;
    localparam int W      = N * SLICES;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic [1:0]    op_i;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic          cin_i;
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  result_o;
    logic          cout_o;
    logic          ovf_o;

    int pass_cnt;
    int total_cnt;

    cla_slice_sequencer_if #(.N(N)) cla_if ();

    // Behavioural stand-in for the external CLA slice
    logic [N:0] add_full;
    assign add_full = {1'b0, cla_if.slice_a} + {1'b0, cla_if.slice_b} + {{N{1'b0}}, cla_if.slice_cin};
    assign cla_if.slice_sum  = add_full[N-1:0];
    assign cla_if.slice_cout = add_full[N];

    cla_slice_sequencer #(.N(N), .SLICES(SLICES)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .cin_i    (cin_i),
        .cla      (cla_if),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .cout_o   (cout_o),
        .ovf_o    (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs [9];

    logic [N-1:0] sb_log  [SLICES];
    logic         cin_log [SLICES];
    logic [W-1:0] r_res;
    logic         r_co;
    logic         r_ov;
    int           r_lat;
    int           r_busy;
    logic         r_done_after;
    logic         r_busy_after;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Issue one op, scramble the inputs after acceptance, wait (bounded) for done
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        op_i    = op;
        a_i     = a;
        b_i     = b;
        cin_i   = c;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        op_i    = 2'($urandom_range(3));
        a_i     = W'($urandom);
        b_i     = W'($urandom);
        cin_i   = 1'($urandom_range(1));
        r_lat   = 1;
        r_busy  = 0;
        for (int i = 0; i < SLICES; i++) begin
            sb_log[i]  = '0;
            cin_log[i] = 1'b0;
        end
        while (!done_o && r_lat < 20) begin
            if (r_lat <= SLICES) begin
                sb_log[r_lat-1]  = cla_if.slice_b;
                cin_log[r_lat-1] = cla_if.slice_cin;
            end
            if (busy_o) r_busy++;
            tick();
            r_lat++;
        end
        if (busy_o) r_busy++;
        r_res = result_o;
        r_co  = cout_o;
        r_ov  = ovf_o;
        tick();
        r_done_after = done_o;
        r_busy_after = busy_o;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        start_i   = 1'b0;
        op_i      = 2'b00;
        a_i       = '0;
        b_i       = '0;
        cin_i     = 1'b0;

        vecs[0] = '{2'b00, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{2'b01, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{2'b01, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{2'b00, 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0};
        vecs[6] = '{2'b11, 16'h0F0F, 16'h00F0, 1'b1, 16'h0FFF, 1'b0, 1'b0};
        vecs[7] = '{2'b10, 16'hFFFF, 16'hA5A5, 1'b1, 16'hA5A5, 1'b0, 1'b0};
        vecs[8] = '{2'b01, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0};

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy",    32'(busy_o),           32'd0);
        chk("rst_done",    32'(done_o),           32'd0);
        chk("rst_result",  32'(result_o),         32'h0);
        chk("rst_cout",    32'(cout_o),           32'd0);
        chk("rst_ovf",     32'(ovf_o),            32'd0);
        chk("rst_slice_a", 32'(cla_if.slice_a),   32'd0);
        chk("rst_slice_b", 32'(cla_if.slice_b),   32'd0);

        // Table-driven operations
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
            chk($sformatf("v%0d_result", i),  32'(r_res),        32'(vecs[i].res));
            chk($sformatf("v%0d_cout", i),    32'(r_co),         32'(vecs[i].co));
            chk($sformatf("v%0d_ovf", i),     32'(r_ov),         32'(vecs[i].ov));
            chk($sformatf("v%0d_latency", i), 32'(r_lat),        32'd5);
            chk($sformatf("v%0d_busy", i),    32'(r_busy),       32'd5);
            chk($sformatf("v%0d_done_once", i), 32'(r_done_after), 32'd0);
            if (i == 0) chk("v0_cin_k1", 32'(cin_log[1]), 32'd1);
            if (i == 3) begin
                chk("v3_slice_b_k0", 32'(sb_log[0]),  32'hE);
                chk("v3_cin_k0",     32'(cin_log[0]), 32'd1);
            end
        end

        // AND then OR with start held high the whole time
        op_i    = 2'b10;
        a_i     = 16'hF0F0;
        b_i     = 16'h3C3C;
        start_i = 1'b1;
        tick();
        op_i  = 2'b11;
        r_lat = 1;
        while (!done_o && r_lat < 20) begin
            tick();
            r_lat++;
        end
        chk("and_latency", 32'(r_lat),    32'd5);
        chk("and_result",  32'(result_o), 32'h3030);
        chk("and_cout",    32'(cout_o),   32'd0);
        chk("and_ovf",     32'(ovf_o),    32'd0);
        tick();
        chk("gap_busy",    32'(busy_o),   32'd0);
        tick();
        chk("or_accept_busy",   32'(busy_o),   32'd1);
        chk("or_accept_clear",  32'(result_o), 32'h0);
        start_i = 1'b0;
        r_lat   = 1;
        while (!done_o && r_lat < 20) begin
            tick();
            r_lat++;
        end
        chk("or_latency", 32'(r_lat),    32'd5);
        chk("or_result",  32'(result_o), 32'hFCFC);
        chk("or_cout",    32'(cout_o),   32'd0);
        chk("or_ovf",     32'(ovf_o),    32'd0);
        tick();

        // Reset during the second RUN cycle aborts without a done pulse
        op_i    = 2'b00;
        a_i     = 16'h1234;
        b_i     = 16'h1111;
        cin_i   = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy",   32'(busy_o),   32'd0);
        chk("abort_result", 32'(result_o), 32'h0);
        r_busy = 0;
        for (int i = 0; i < 8; i++) begin
            if (done_o) r_busy++;
            tick();
        end
        chk("abort_no_done", 32'(r_busy), 32'd0);
        run_op(2'b00, 16'h0001, 16'h0001, 1'b0);
        chk("post_abort_result",  32'(r_res), 32'h0002);
        chk("post_abort_latency", 32'(r_lat), 32'd5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
